lif_injector: RTL
=================

LIF_INJECTOR -- requirements
Module: lif_injector

Interface
REQ-001 Parameter LANES, default 4, number of boundary lanes driven (2..8).
REQ-002 Parameter GAP, default 2, idle cycles between consecutive injections on the active lane (0..15).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_lane  input  3  target lane index; values >= LANES are invalid.
REQ-008 cmd_dir  input  2  particle direction: 0->4'b0001, 1->4'b0010, 2->4'b0100, 3->4'b1000.
REQ-009 cmd_count  input  8  number of particles to inject.
REQ-010 cmd_abort  input  1  cancel the active command.
REQ-011 lane_occupied  input  LANES  per-lane flag; 1 = boundary cell state nonzero, so injection is blocked.
REQ-012 inj  output  4*LANES  registered particle code per lane; lane i occupies bits [4i+3:4i].
REQ-013 busy  output  1  high in INJECT or GAP.
REQ-014 done  output  1  one-cycle pulse on command completion.
REQ-015 total  output  16  particles injected since reset; saturates at 16'hFFFF.

Function
REQ-016 FSM states: IDLE, INJECT, GAP, DONE.
REQ-017 cmd_ready SHALL equal (state==IDLE); a command is accepted on an edge where cmd_valid && cmd_ready && rst_n.
REQ-018 On accept: latch lane, dir code and count into internal registers; the host may change its inputs afterwards.
REQ-019 Accept with cmd_count==0 or cmd_lane>=LANES -> DONE; no injection.
REQ-020 Any other accept -> INJECT.
REQ-021 INJECT edge, lane_occupied[lane]==0: inj[lane] <= code for exactly one cycle; remaining -= 1; total += 1 (saturating).
REQ-022 After that injection: remaining==0 -> DONE; else GAP>0 -> GAP with gap counter loaded to GAP; else stay in INJECT.
REQ-023 INJECT edge, lane_occupied[lane]==1: stay in INJECT; inj all zero; remaining unchanged; retry on each later edge until the lane is free.
REQ-024 GAP: inj all zero; gap counter decrements each edge; on the edge where it reads 1 -> INJECT.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 All inj lanes other than the active lane are always zero; at most one nonzero 4-bit code is driven in any cycle.
REQ-027 cmd_abort high on an edge in INJECT or GAP -> IDLE; inj zero from that edge; no done pulse; remaining discarded; total keeps its value.
REQ-028 cmd_abort in IDLE or DONE is ignored; a DONE pulse still completes.
REQ-029 If cmd_abort and an unblocked injection coincide on the same INJECT edge, abort wins and no particle is emitted.
REQ-030 Latency: accept on edge N; with the lane free, the first code is visible on inj from edge N+1; successive codes are spaced GAP+1 cycles apart.

Reset
REQ-031 rst_n low on an edge: state=IDLE, inj=0, done=0, busy=0, total=0, internal counters=0.
REQ-032 Reset takes priority over accept, abort and injection, including reset asserted mid-command.
REQ-033 cmd_ready=1 from the first edge after rst_n deasserts.

Verification
REQ-034 lane=1, dir=2, count=3, GAP=2, lane free -> inj[7:4]=4'b0100 after edges N+1, N+4 and N+7; done one cycle later; total=3.
REQ-035 count=2 with lane_occupied[lane] held high for 5 cycles after accept -> first code delayed exactly 5 cycles, no skipped particle, total=2.
REQ-036 count=0, and separately lane=LANES -> done pulse, inj stays 0, total unchanged.
REQ-037 count=10, abort asserted after the 4th injection -> returns to IDLE, no done pulse, total=4, cmd_ready=1 next cycle.
REQ-038 total preloaded near 16'hFFFF by repeated commands -> stays at 16'hFFFF, no wrap.
REQ-039 rst_n low during GAP -> all outputs zero at the next edge; a new command is accepted normally after reset releases.

Source files
------------

// File: rtl/lif_injector.sv
`default_nettype none
// ============================================================================
//  Module      : lif_injector
//  Description : Injects particle codes into one boundary lane of a lattice
//                gas grid. A host command selects lane, direction and count;
//                particles are emitted one per slot, GAP idle cycles apart,
//                retrying while the target boundary cell is occupied.
//  Revision    : 1.0  initial release
// ============================================================================
module lif_injector #(
    parameter int LANES = 4,
    parameter int GAP   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_lane,
    input  logic [1:0]           cmd_dir,
    input  logic [7:0]           cmd_count,
    input  logic                 cmd_abort,
    input  logic [LANES-1:0]     lane_occupied,
    output logic [4*LANES-1:0]   inj,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          total
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INJECT = 2'd1,
        S_GAP    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LW-1:0]      r_lane;
    logic [3:0]         r_code;
    logic [7:0]         r_rem;
    logic [3:0]         r_gap;
    logic [4*LANES-1:0] r_inj;
    logic [15:0]        r_total;

    logic               w_accept;
    logic               w_fire;
    logic               w_abort;
    logic               w_cmd_bad;
    logic               w_lane_free;
    logic [4*LANES-1:0] w_inj_next;

    // A zero count or an out-of-range lane completes without injecting.
    assign w_cmd_bad   = (cmd_count == 8'd0) || ({1'b0, cmd_lane} >= 4'(LANES));
    assign w_lane_free = !lane_occupied[r_lane];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; abort outranks an unblocked injection.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_cmd_bad ? S_DONE : S_INJECT;
                end
            end
            S_INJECT: begin
                if (cmd_abort) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_lane_free) begin
                    w_fire = 1'b1;
                    if (r_rem == 8'd1) begin
                        w_state_next = S_DONE;
                    end else if (GAP > 0) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_state_next = S_INJECT;
                    end
                end
            end
            S_GAP: begin
                if (cmd_abort) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_gap == 4'd1) begin
                    w_state_next = S_INJECT;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Place the latched code on the active lane only when a particle fires.
    always_comb begin
        w_inj_next = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_fire && (r_lane == LW'(i))) begin
                w_inj_next[4*i +: 4] = r_code;
            end
        end
    end

    // Command latch, particle/gap counters, output register and running total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane  <= '0;
            r_code  <= '0;
            r_rem   <= '0;
            r_gap   <= '0;
            r_inj   <= '0;
            r_total <= '0;
        end else begin
            r_inj <= w_inj_next;
            if (w_accept) begin
                r_lane <= cmd_lane[LW-1:0];
                r_code <= 4'b0001 << cmd_dir;
                r_rem  <= cmd_count;
            end else if (w_abort) begin
                r_rem <= '0;
                r_gap <= '0;
            end else if (w_fire) begin
                r_rem <= r_rem - 8'd1;
                r_gap <= 4'(GAP);
                if (r_total != 16'hFFFF) begin
                    r_total <= r_total + 16'd1;
                end
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap - 4'd1;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_INJECT) || (r_state == S_GAP);
    assign done      = (r_state == S_DONE);
    assign inj       = r_inj;
    assign total     = r_total;

endmodule
`default_nettype wire
